// File: rtl/decade_pkg.sv
// Shared constants and helpers for the BCD down-timer and its digit slices.
package decade_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Non-decimal nibbles (A-F) saturate to 9 so the count stays valid BCD.
    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One combinational BCD digit decrement slice with borrow ripple.
module bcd_digit_down
    import decade_pkg::*;
(
    input  logic [BCD_W-1:0] d_in,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] d_out,
    output logic             borrow_out
);

    always_comb begin
        d_out      = d_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (d_in == '0) begin
                d_out      = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                d_out = d_in - BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/decade_down_timer.sv
// Cascadable BCD down-counter/timer: load a preset, count down on en after start,
// pulse done at zero and optionally reload the preset.
module decade_down_timer
    import decade_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter bit          RELOAD = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    input  logic                    start,
    input  logic                    en,
    output logic [BCD_W*DIGITS-1:0] out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CW = BCD_W * DIGITS;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CW-1:0]     preset;
    logic [CW-1:0]     preset_nxt;
    logic [CW-1:0]     out_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic [CW-1:0]     load_clamped;
    logic [CW-1:0]     dec_val;
    logic [DIGITS:0]   borrow;
    logic [DIGITS-1:0] digit_zero;
    logic [DIGITS-1:0] dec_digit_zero;
    logic              count_zero;
    logic              dec_zero;

    // Ripple-borrow decrement chain; digit 0 always borrows to subtract one.
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_down u_digit (
            .d_in      (out[g*BCD_W +: BCD_W]),
            .borrow_in (borrow[g]),
            .d_out     (dec_val[g*BCD_W +: BCD_W]),
            .borrow_out(borrow[g+1])
        );
        assign digit_zero[g]     = (out[g*BCD_W +: BCD_W] == '0);
        assign dec_digit_zero[g] = (dec_val[g*BCD_W +: BCD_W] == '0);
    end

    assign count_zero = &digit_zero;
    assign dec_zero   = &dec_digit_zero;

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_clamped[i*BCD_W +: BCD_W] = clamp_digit(load_val[i*BCD_W +: BCD_W]);
        end
    end

    // Next-state and next-output logic; load overrides every state.
    always_comb begin
        state_nxt  = state;
        out_nxt    = out;
        preset_nxt = preset;
        if (load) begin
            out_nxt    = load_clamped;
            preset_nxt = load_clamped;
            state_nxt  = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !count_zero) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A borrow out of the top digit would mean a wrap from zero; refuse it.
                    if (en && !borrow[DIGITS]) begin
                        out_nxt = dec_val;
                        if (dec_zero) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (RELOAD && (preset != '0)) begin
                        out_nxt   = preset;
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
        busy_nxt = (state_nxt == ST_RUN);
        done_nxt = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            out    <= '0;
            preset <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            out    <= out_nxt;
            preset <= preset_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_decade_down_timer.sv
// Bench for decade_down_timer: one non-reloading and one reloading instance share
// stimulus and are checked against a decimal-arithmetic reference model.
module tb_decade_down_timer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       en;
    logic [7:0] out_w  [2];
    logic       busy_w [2];
    logic       done_w [2];

    int m_cnt  [2];
    int m_pre  [2];
    int m_mode [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decade_down_timer #(.DIGITS(2), .RELOAD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .en(en), .out(out_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    decade_down_timer #(.DIGITS(2), .RELOAD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .en(en), .out(out_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int clamp_dec(input logic [7:0] v);
        int hi;
        int lo;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic logic [9:0] exp_vec(input int k);
        return {to_bcd(m_cnt[k]), 1'b0 | (m_mode[k] == M_RUN), 1'b0 | (m_mode[k] == M_DONE)};
    endfunction

    function automatic logic [9:0] obs(input int k);
        return {out_w[k], busy_w[k], done_w[k]};
    endfunction

    // Reference behaviour of one clock edge for both instances (k==1 reloads).
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_mode[k] = M_IDLE;
            end else if (load) begin
                m_cnt[k] = clamp_dec(load_val); m_pre[k] = m_cnt[k]; m_mode[k] = M_IDLE;
            end else if (m_mode[k] == M_IDLE) begin
                if (start && m_cnt[k] != 0) m_mode[k] = M_RUN;
            end else if (m_mode[k] == M_RUN) begin
                if (en) begin
                    m_cnt[k] = m_cnt[k] - 1;
                    if (m_cnt[k] == 0) m_mode[k] = M_DONE;
                end
            end else begin
                if (k == 1 && m_pre[k] != 0) begin
                    m_cnt[k] = m_pre[k]; m_mode[k] = M_RUN;
                end else begin
                    m_mode[k] = M_IDLE;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; load = 1'b1; load_val = 8'h55; start = 1'b1; en = 1'b1;
        repeat (2) begin
            step();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== 10'h000) begin
                    miscompares++;
                    $display("FAIL reset dut%0d: got %h want %h", k, obs(k), 10'h000);
                end
            end
        end
        reset = 1'b1; load = 1'b0; start = 1'b0; en = 1'b0;
    endtask

    task automatic test_count12();
        load = 1'b1; load_val = 8'h12;
        step();
        load = 1'b0; start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL count12 dut%0d edge %0d: got %h want %h", k, i, obs(k), exp_vec(k));
                end
            end
            if (i == 12) begin
                vectors++;
                if (obs(0) !== {8'h00, 1'b0, 1'b1}) begin
                    miscompares++;
                    $display("FAIL count12_done: got %h want %h", obs(0), {8'h00, 1'b0, 1'b1});
                end
            end
        end
        vectors++;
        if (obs(0) !== {8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL count12_idle_hold: got %h want %h", obs(0), {8'h00, 1'b0, 1'b0});
        end
        en = 1'b0;
    endtask

    task automatic test_en_toggle();
        load = 1'b1; load_val = 8'h05;
        step();
        load = 1'b0; start = 1'b1; en = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en = (i % 2 == 1);
            step();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL en_toggle dut%0d edge %0d: got %h want %h", k, i + 1, obs(k), exp_vec(k));
                end
            end
        end
        vectors++;
        if (obs(0) !== {8'h00, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL en_toggle_done: got %h want %h", obs(0), {8'h00, 1'b0, 1'b1});
        end
        en = 1'b0;
    endtask

    task automatic test_reload();
        load = 1'b1; load_val = 8'h03;
        step();
        load = 1'b0; start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL reload dut%0d edge %0d: got %h want %h", k, i + 1, obs(k), exp_vec(k));
                end
            end
        end
        load = 1'b1; load_val = 8'h02;
        step();
        load = 1'b0; en = 1'b0;
        vectors++;
        if (obs(1) !== {8'h02, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reload_midrun_load: got %h want %h", obs(1), {8'h02, 1'b0, 1'b0});
        end
    endtask

    task automatic test_clamp_zero();
        load = 1'b1; load_val = 8'hAF;
        step();
        load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs(k) !== {8'h99, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL clamp dut%0d: got %h want %h", k, obs(k), {8'h99, 1'b0, 1'b0});
            end
        end
        load = 1'b1; load_val = 8'h00;
        step();
        load = 1'b0; start = 1'b1; en = 1'b1;
        repeat (3) begin
            step();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== 10'h000) begin
                    miscompares++;
                    $display("FAIL zero_start dut%0d: got %h want %h", k, obs(k), 10'h000);
                end
            end
        end
        start = 1'b0; en = 1'b0;
    endtask

    task automatic test_midrun_reset();
        load = 1'b1; load_val = 8'h09;
        step();
        load = 1'b0; start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        vectors++;
        if (obs(0) !== {8'h05, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL midrun_at5: got %h want %h", obs(0), {8'h05, 1'b1, 1'b0});
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        vectors++;
        if (obs(0) !== 10'h000) begin
            miscompares++;
            $display("FAIL midrun_reset: got %h want %h", obs(0), 10'h000);
        end
        load = 1'b1; load_val = 8'h07; start = 1'b1; en = 1'b0;
        step();
        load = 1'b0;
        vectors++;
        if (obs(0) !== {8'h07, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL load_beats_start: got %h want %h", obs(0), {8'h07, 1'b0, 1'b0});
        end
        step();
        start = 1'b0;
        vectors++;
        if (obs(0) !== {8'h07, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL start_after_load: got %h want %h", obs(0), {8'h07, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(31) != 0);
            load     = ($urandom_range(15) == 0);
            load_val = 8'($urandom());
            start    = ($urandom_range(3) == 0);
            en       = ($urandom_range(1) == 1);
            step();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL random dut%0d cycle %0d: got %h want %h", k, i, obs(k), exp_vec(k));
                end
            end
        end
        reset = 1'b1; load = 1'b0; start = 1'b0; en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_val = 8'h00; start = 1'b0; en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_mode[k] = M_IDLE;
        end
        #2;
        test_reset();
        test_count12();
        test_en_toggle();
        test_reload();
        test_clamp_zero();
        test_midrun_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
